// File: rtl/cpu_iface_bridge.sv
// AXI4-Lite slave to internal CPU register-bus bridge.
// One outstanding access, alternating read/write arbitration, wait-state
// handshake via CPUReady and an optional timeout that ends a stalled access
// with SLVERR.
module cpu_iface_bridge #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    // AXI4-Lite read address / data
    input  logic [31:0]             araddr,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready,
    // AXI4-Lite write address / data / response
    input  logic [31:0]             awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    // Register-bank side
    output logic                    CPURead,
    output logic                    CPUWrite,
    output logic [ADDR_WIDTH-1:0]   CPUAddress,
    output logic [DATA_WIDTH-1:0]   CPUWriteData,
    output logic [DATA_WIDTH/8-1:0] CPUWriteStrobe,
    input  logic [DATA_WIDTH-1:0]   CPUReadData,
    input  logic                    CPUReady
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Counter value seen in the last permitted wait cycle
    localparam int unsigned TO_LAST    = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam bit          TO_EN      = (TIMEOUT_CYCLES != 0);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        WR_WAIT = 3'd2,
        RD_RESP = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   last_wr;     // 1: most recent grant was a write
    logic [CNT_WIDTH-1:0]   wait_cnt;
    logic                   rd_grant;
    logic                   wr_grant;
    logic                   done_ok;
    logic                   done_to;
    logic                   in_wait;

    // Upper address bits are intentionally dropped
    logic unused_addr_bits;
    assign unused_addr_bits = ^{araddr, awaddr};

    assign in_wait  = (state == RD_WAIT) || (state == WR_WAIT);
    assign CPURead  = (state == RD_WAIT);
    assign CPUWrite = (state == WR_WAIT);
    assign rvalid   = (state == RD_RESP);
    assign bvalid   = (state == WR_RESP);

    // Next-state, arbitration and AXI ready decode
    always_comb begin
        state_nxt = state;
        rd_grant  = 1'b0;
        wr_grant  = 1'b0;
        done_ok   = 1'b0;
        done_to   = 1'b0;
        arready   = 1'b0;
        awready   = 1'b0;
        wready    = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the side that did not go last wins
                if (arvalid && (!(awvalid && wvalid) || last_wr)) begin
                    rd_grant = 1'b1;
                end else if (awvalid && wvalid) begin
                    wr_grant = 1'b1;
                end
                arready = rd_grant;
                awready = wr_grant;
                wready  = wr_grant;
                if (rd_grant) begin
                    state_nxt = RD_WAIT;
                end else if (wr_grant) begin
                    state_nxt = WR_WAIT;
                end
            end
            RD_WAIT, WR_WAIT: begin
                // CPUReady takes priority over a coincident timeout
                if (CPUReady) begin
                    done_ok = 1'b1;
                end else if (TO_EN && (wait_cnt == CNT_WIDTH'(TO_LAST))) begin
                    done_to = 1'b1;
                end
                if (done_ok || done_to) begin
                    state_nxt = (state == RD_WAIT) ? RD_RESP : WR_RESP;
                end
            end
            RD_RESP: begin
                if (rready) begin
                    state_nxt = IDLE;
                end
            end
            WR_RESP: begin
                if (bready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and arbitration history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            last_wr <= 1'b1;
        end else begin
            state <= state_nxt;
            if (rd_grant) begin
                last_wr <= 1'b0;
            end else if (wr_grant) begin
                last_wr <= 1'b1;
            end
        end
    end

    // Wait-cycle counter, cleared on every grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (rd_grant || wr_grant) begin
            wait_cnt <= '0;
        end else if (in_wait && !CPUReady) begin
            wait_cnt <= wait_cnt + CNT_WIDTH'(1);
        end
    end

    // Request capture towards the register bank
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            CPUAddress     <= '0;
            CPUWriteData   <= '0;
            CPUWriteStrobe <= '0;
        end else if (rd_grant) begin
            CPUAddress     <= araddr[ADDR_WIDTH-1:0];
        end else if (wr_grant) begin
            CPUAddress     <= awaddr[ADDR_WIDTH-1:0];
            CPUWriteData   <= wdata;
            CPUWriteStrobe <= wstrb[STRB_WIDTH-1:0];
        end
    end

    // Response capture, held until the AXI response handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
            rresp <= RESP_OKAY;
            bresp <= RESP_OKAY;
        end else if (state == RD_WAIT) begin
            if (done_ok) begin
                rdata <= CPUReadData;
                rresp <= RESP_OKAY;
            end else if (done_to) begin
                rdata <= '0;
                rresp <= RESP_SLVERR;
            end
        end else if (state == WR_WAIT) begin
            if (done_ok) begin
                bresp <= RESP_OKAY;
            end else if (done_to) begin
                bresp <= RESP_SLVERR;
            end
        end
    end

endmodule

// File: tb/tb_cpu_iface_bridge.sv
// Self-checking bench for cpu_iface_bridge: directed scenarios followed by
// randomized accesses compared against a transaction-level reference model.
module tb_cpu_iface_bridge;

    localparam int TO = 8;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          cycles;
        bit          stable;
    } acc_t;

    logic        clk;
    logic        reset;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        CPURead;
    logic        CPUWrite;
    logic [15:0] CPUAddress;
    logic [31:0] CPUWriteData;
    logic [3:0]  CPUWriteStrobe;
    logic [31:0] CPUReadData;
    logic        CPUReady;

    int checks = 0;
    int errors = 0;

    // Register-bank responder configuration: ready in wait cycle rdy_at (0 = never)
    int          rdy_at = 1;
    logic [31:0] rd_val = '0;

    // Observations gathered by the monitor
    bit          grant_q[$];
    logic [33:0] rq[$];
    logic [1:0]  bq[$];
    acc_t        acc_q[$];
    acc_t        cur;
    bit          in_acc = 0;
    bit          overlap_err = 0;
    bit          split_err = 0;

    // Reference model state: kind of the last granted access
    bit          exp_last_wr = 1;

    cpu_iface_bridge #(
        .ADDR_WIDTH    (16),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .araddr        (araddr),
        .arvalid       (arvalid),
        .arready       (arready),
        .rdata         (rdata),
        .rresp         (rresp),
        .rvalid        (rvalid),
        .rready        (rready),
        .awaddr        (awaddr),
        .awvalid       (awvalid),
        .awready       (awready),
        .wdata         (wdata),
        .wstrb         (wstrb),
        .wvalid        (wvalid),
        .wready        (wready),
        .bresp         (bresp),
        .bvalid        (bvalid),
        .bready        (bready),
        .CPURead       (CPURead),
        .CPUWrite      (CPUWrite),
        .CPUAddress    (CPUAddress),
        .CPUWriteData  (CPUWriteData),
        .CPUWriteStrobe(CPUWriteStrobe),
        .CPUReadData   (CPUReadData),
        .CPUReady      (CPUReady)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register bank model: counts wait cycles and raises CPUReady on schedule
    initial begin
        int cnt;
        cnt = 0;
        CPUReady = 1'b0;
        CPUReadData = '0;
        forever begin
            @(posedge clk);
            #1;
            if (CPURead === 1'b1 || CPUWrite === 1'b1) begin
                cnt++;
                CPUReady = (rdy_at != 0) && (cnt >= rdy_at);
                CPUReadData = CPUReady ? rd_val : $urandom;
            end else begin
                cnt = 0;
                CPUReady = 1'b0;
            end
        end
    end

    // Monitor: records handshakes, bank accesses and responses mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (arvalid && arready) grant_q.push_back(1'b0);
            if (awvalid && wvalid && awready && wready) grant_q.push_back(1'b1);
            if ((awready !== wready) || (awready === 1'b1 && !(awvalid && wvalid))) split_err = 1;
            if (CPURead === 1'b1 && CPUWrite === 1'b1) overlap_err = 1;
            if (CPURead === 1'b1 || CPUWrite === 1'b1) begin
                if (!in_acc) begin
                    cur.wr     = CPUWrite;
                    cur.addr   = CPUAddress;
                    cur.data   = CPUWriteData;
                    cur.strb   = CPUWriteStrobe;
                    cur.cycles = 1;
                    cur.stable = 1;
                    in_acc     = 1;
                end else begin
                    cur.cycles++;
                    if (cur.wr !== CPUWrite || cur.addr !== CPUAddress) cur.stable = 0;
                    if (cur.wr && (cur.data !== CPUWriteData || cur.strb !== CPUWriteStrobe)) cur.stable = 0;
                end
            end else if (in_acc) begin
                acc_q.push_back(cur);
                in_acc = 0;
            end
            if (rvalid === 1'b1 && rready) rq.push_back({rdata, rresp});
            if (bvalid === 1'b1 && bready) bq.push_back(bresp);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        grant_q.delete();
        rq.delete();
        bq.delete();
        acc_q.delete();
    endtask

    function automatic bit times_out(input int r);
        return (r == 0) || (r > TO);
    endfunction

    // Compare one recorded bank access and its response against the model
    task automatic check_access(input bit is_wr, input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, input int rdy, input logic [31:0] rval);
        bit          to;
        acc_t        a;
        logic [33:0] r;
        logic [1:0]  b;
        to = times_out(rdy);
        if (is_wr) begin
            chk("bresp_seen", 64'(bq.size() != 0), 64'(1));
            if (bq.size() != 0) begin
                b = bq.pop_front();
                chk("bresp", 64'(b), to ? 64'(2) : 64'(0));
            end
        end else begin
            chk("rresp_seen", 64'(rq.size() != 0), 64'(1));
            if (rq.size() != 0) begin
                r = rq.pop_front();
                chk("rresp", 64'(r[1:0]), to ? 64'(2) : 64'(0));
                chk("rdata", 64'(r[33:2]), to ? 64'(0) : 64'(rval));
            end
        end
        chk("acc_seen", 64'(acc_q.size() != 0), 64'(1));
        if (acc_q.size() != 0) begin
            a = acc_q.pop_front();
            chk("acc_kind", 64'(a.wr), 64'(is_wr));
            chk("acc_addr", 64'(a.addr), 64'(addr[15:0]));
            chk("acc_cycles", 64'(a.cycles), to ? 64'(TO) : 64'(rdy));
            chk("acc_stable", 64'(a.stable), 64'(1));
            if (is_wr) begin
                chk("acc_wdata", 64'(a.data), 64'(data));
                chk("acc_wstrb", 64'(a.strb), 64'(strb));
            end
        end
    endtask

    // One isolated access; w_lag delays wvalid behind awvalid
    task automatic single(input bit is_wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int rdy, input logic [31:0] rval,
                          input int w_lag);
        bit got;
        clear_obs();
        rdy_at = rdy;
        rd_val = rval;
        rready = 1'b1;
        bready = 1'b1;
        if (is_wr) begin
            awaddr  = addr;
            wdata   = data;
            wstrb   = strb;
            awvalid = 1'b1;
            for (int i = 0; i < w_lag; i++) begin
                #1;
                chk("aw_alone_awready", 64'(awready), 64'(0));
                chk("aw_alone_wready", 64'(wready), 64'(0));
                tick();
            end
            wvalid = 1'b1;
        end else begin
            araddr  = addr;
            arvalid = 1'b1;
        end
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            got = is_wr ? (awready && wready) : arready;
            tick();
        end
        chk(is_wr ? "wr_grant" : "rd_grant", 64'(got), 64'(1));
        arvalid = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        for (int i = 0; i < 40 && (is_wr ? bq.size() == 0 : rq.size() == 0); i++) tick();
        check_access(is_wr, addr, data, strb, rdy, rval);
        exp_last_wr = is_wr;
        tick();
    endtask

    // Read and write both presented continuously for n grants
    task automatic held(input int n, input int rdy, input logic [31:0] rval, input logic [31:0] ra,
                        input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws);
        bit exp_wr;
        bit k;
        clear_obs();
        rdy_at  = rdy;
        rd_val  = rval;
        rready  = 1'b1;
        bready  = 1'b1;
        araddr  = ra;
        awaddr  = wa;
        wdata   = wd;
        wstrb   = ws;
        arvalid = 1'b1;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        for (int i = 0; i < 150 && grant_q.size() < n; i++) tick();
        arvalid = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        chk("held_grants", 64'(grant_q.size()), 64'(n));
        for (int i = 0; i < 40 && (rq.size() + bq.size()) < n; i++) tick();
        exp_wr = !exp_last_wr;
        for (int i = 0; i < n; i++) begin
            if (grant_q.size() != 0) begin
                k = grant_q.pop_front();
                chk("grant_order", 64'(k), 64'(exp_wr));
            end
            check_access(exp_wr, exp_wr ? wa : ra, wd, ws, rdy, rval);
            exp_last_wr = exp_wr;
            exp_wr = !exp_wr;
        end
        tick();
    endtask

    initial begin
        int          rdy;
        int          mode;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [3:0]  s0;

        reset   = 1'b1;
        araddr  = '0;
        arvalid = 1'b0;
        rready  = 1'b0;
        awaddr  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_arready", 64'(arready), 64'(0));
        chk("rst_awready", 64'(awready), 64'(0));
        chk("rst_wready", 64'(wready), 64'(0));
        chk("rst_rvalid", 64'(rvalid), 64'(0));
        chk("rst_bvalid", 64'(bvalid), 64'(0));
        chk("rst_cpuread", 64'(CPURead), 64'(0));
        chk("rst_cpuwrite", 64'(CPUWrite), 64'(0));
        chk("rst_rdata", 64'(rdata), 64'(0));
        chk("rst_rresp", 64'(rresp), 64'(0));
        chk("rst_bresp", 64'(bresp), 64'(0));
        chk("rst_cpuaddr", 64'(CPUAddress), 64'(0));
        chk("rst_cpuwdata", 64'(CPUWriteData), 64'(0));
        chk("rst_cpustrb", 64'(CPUWriteStrobe), 64'(0));
        reset = 1'b0;
        tick();

        // Read at 0x1234 with cycle-exact latency and response hold
        rdy_at  = 1;
        rd_val  = 32'hCAFE_F00D;
        araddr  = 32'h0000_1234;
        arvalid = 1'b1;
        #1;
        chk("t1_arready_c0", 64'(arready), 64'(1));
        tick();
        arvalid = 1'b0;
        chk("t1_cpuread_c1", 64'(CPURead), 64'(1));
        chk("t1_cpuaddr", 64'(CPUAddress), 64'(16'h1234));
        chk("t1_rvalid_c1", 64'(rvalid), 64'(0));
        tick();
        chk("t1_rvalid_c2", 64'(rvalid), 64'(1));
        chk("t1_cpuread_c2", 64'(CPURead), 64'(0));
        chk("t1_rdata", 64'(rdata), 64'(32'hCAFE_F00D));
        chk("t1_rresp", 64'(rresp), 64'(0));
        tick();
        tick();
        chk("t1_rvalid_hold", 64'(rvalid), 64'(1));
        chk("t1_rdata_hold", 64'(rdata), 64'(32'hCAFE_F00D));
        rready = 1'b1;
        tick();
        chk("t1_rvalid_done", 64'(rvalid), 64'(0));
        exp_last_wr = 0;
        tick();

        // Write with delayed CPUReady, then AW waiting on W
        single(1, 32'h0000_0008, 32'h1122_3344, 4'b0101, 5, '0, 0);
        single(1, 32'h0000_0010, 32'hA5A5_5A5A, 4'b1111, 1, '0, 3);

        // Alternating grants under continuous contention
        held(4, 1, 32'h0BAD_CAFE, 32'h0000_0040, 32'h0000_0044, 32'h7777_8888, 4'b1010);

        // Timeout boundaries: never ready, ready on the last cycle, one too late
        single(0, 32'h0000_0100, '0, '0, 0, 32'h1111_1111, 0);
        single(0, 32'h0000_0104, '0, '0, 2, 32'h2222_2222, 0);
        single(0, 32'h0000_0108, '0, '0, TO, 32'h3333_3333, 0);
        single(1, 32'h0000_010C, 32'h4444_4444, 4'b0000, TO + 1, '0, 0);

        // Reset while a read is waiting on the bank
        clear_obs();
        rdy_at  = 0;
        araddr  = 32'h0000_0055;
        arvalid = 1'b1;
        #1;
        chk("rst_mid_grant", 64'(arready), 64'(1));
        tick();
        arvalid = 1'b0;
        chk("rst_mid_cpuread", 64'(CPURead), 64'(1));
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("rst_mid_drop", 64'(CPURead), 64'(0));
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("rst_mid_no_rvalid", 64'(rq.size()), 64'(0));
        exp_last_wr = 1;
        single(0, 32'h0000_00A0, '0, '0, 2, 32'h5566_7788, 0);

        // Randomized accesses against the reference model
        for (int it = 0; it < 40; it++) begin
            mode = int'($urandom_range(0, 2));
            rdy  = int'($urandom_range(0, TO + 2));
            a0   = $urandom;
            a1   = $urandom;
            d0   = $urandom;
            d1   = $urandom;
            s0   = 4'($urandom);
            case (mode)
                0:       single(0, a0, '0, '0, rdy, d1, 0);
                1:       single(1, a1, d0, s0, rdy, '0, int'($urandom_range(0, 2)));
                default: held(2, rdy, d1, a0, a1, d0, s0);
            endcase
        end

        chk("no_rd_wr_overlap", 64'(overlap_err), 64'(0));
        chk("aw_w_together", 64'(split_err), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_iface_bridge.md
Name: cpu_iface_bridge

Overview:
- Parametrised AXI4-Lite slave to internal CPU register-bus bridge; successor to the fixed 16/32-bit single-cycle converter.
- Adds configurable address/data width, a proper W-channel handshake with byte strobes, and a wait-state handshake (CPUReady) from the register bank.
- Adds a timeout that terminates a stalled access with SLVERR, and fair read/write arbitration.
- Sits between the host AXI-Lite port and every register bank in the design.

Parameters:
- ADDR_WIDTH, 16, width of CPUAddress; low ADDR_WIDTH bits of the AXI address are forwarded.
- DATA_WIDTH, 32, data width; must be 32 or 64; STRB_WIDTH = DATA_WIDTH/8.
- TIMEOUT_CYCLES, 255, maximum wait cycles for CPUReady; 0 disables timeout.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- araddr  in  32  read address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  DATA_WIDTH  read data
- rresp  out  2  read response
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- awaddr  in  32  write address
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  DATA_WIDTH  write data
- wstrb  in  STRB_WIDTH  write byte strobes
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  write response
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- CPURead  out  1  read request; held until completion
- CPUWrite  out  1  write request; held until completion
- CPUAddress  out  ADDR_WIDTH  registered access address
- CPUWriteData  out  DATA_WIDTH  registered write data
- CPUWriteStrobe  out  STRB_WIDTH  registered byte enables
- CPUReadData  in  DATA_WIDTH  read data; valid when CPUReady is high
- CPUReady  in  1  access complete

Behaviour:
- Reset (async assert, sync release): state IDLE; all ready/valid outputs 0; CPURead/CPUWrite 0; rdata, CPUAddress, CPUWriteData, CPUWriteStrobe 0; rresp/bresp 0; last_grant = write (first tie goes to read); timeout counter 0.
- Reset mid-access drops CPURead/CPUWrite immediately. The transaction is lost; no response is issued.
- States: IDLE, RD_WAIT, WR_WAIT, RD_RESP, WR_RESP.
- IDLE:
  - Read candidate = arvalid.
  - Write candidate = awvalid & wvalid; AW and W are accepted only together, never one alone.
  - Only one candidate: grant it.
  - Both candidates: grant the opposite of last_grant.
  - arready is high only in IDLE, and only for the cycle the read is granted; awready and wready likewise for a write grant. Ready outputs are combinational from state and the valids.
- On read grant: latch araddr[ADDR_WIDTH-1:0], set last_grant = read, go to RD_WAIT.
- On write grant: latch address, wdata and wstrb, set last_grant = write, go to WR_WAIT.
- RD_WAIT / WR_WAIT:
  - CPURead or CPUWrite is high every cycle in the state; address, data and strobe stay stable.
  - CPUReady high: read captures CPUReadData into rdata with rresp = OKAY (2'b00); write sets bresp = OKAY. Go to the RESP state.
  - Timeout counter increments each WAIT cycle without CPUReady. If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES, end the access: read returns rdata = 0 with rresp = SLVERR (2'b10); write returns bresp = SLVERR. Go to the RESP state.
  - If CPUReady arrives in the same cycle as the timeout, CPUReady wins and the response is OKAY.
  - Counter clears on entry to each WAIT state.
- RD_RESP: rvalid = 1; rdata and rresp stay stable until rready; then go to IDLE.
- WR_RESP: bvalid = 1; bresp stays stable until bready; then go to IDLE.
- Latency with CPUReady asserted in the first wait cycle:
  - AR handshake at cycle 0; CPURead at cycle 1; rvalid at cycle 2.
  - Back-to-back accesses need one IDLE cycle between them.
- Only one outstanding transaction. CPURead and CPUWrite are never high together.
- Strobe = 0 writes are forwarded unchanged; the register bank ignores the disabled bytes.

Test Plan:
- Read at 0x0000_1234, CPUReady high in cycle 1 with CPUReadData = 0xCAFEF00D -> CPUAddress = 0x1234; rvalid at cycle 2; rdata = 0xCAFEF00D; rresp = 0.
- Write to 0x0008, wdata = 0x11223344, wstrb = 4'b0101, CPUReady delayed 5 cycles -> CPUWrite held 5 cycles with stable CPUWriteStrobe = 0101; then bvalid with bresp = 0.
- awvalid high with wvalid low for 3 cycles -> awready stays 0; both handshakes occur together once wvalid rises.
- arvalid and (awvalid & wvalid) held high for 4 transactions -> grants alternate read, write, read, write.
- TIMEOUT_CYCLES = 8, CPUReady never asserted on a read -> CPURead high for exactly 8 cycles; rresp = 2'b10; rdata = 0; the next access proceeds normally.
- Assert reset during RD_WAIT -> CPURead drops that cycle; no rvalid is issued; a new read after reset completes with OKAY.
